// File: rtl/lif_tdm_sched.sv
// Time-multiplexed leaky-integrate-and-fire scheduler: one shared update datapath sweeps
// N membranes per timestep and queues spike events in a small FIFO. Define LIF_REFRAC_EN for refractory counters.
module lif_tdm_sched #(
    parameter int unsigned N_NEURONS    = 4,
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned REFRAC_STEPS = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          step_i,
    input  logic [N_NEURONS*WIDTH-1:0]    cur_i,
    input  logic [WIDTH-1:0]              beta_i,
    input  logic [WIDTH-1:0]              thresh_i,
    input  logic                          clr_flags_i,
    input  logic [$clog2(N_NEURONS)-1:0]  rd_sel_i,
    output logic [WIDTH-1:0]              rd_mem_o,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [N_NEURONS-1:0]          spike_vec_o,
    output logic                          ev_valid_o,
    output logic [$clog2(N_NEURONS)-1:0]  ev_id_o,
    input  logic                          ev_ready_i,
    output logic                          ovf_o,
    output logic                          step_miss_o
);

    localparam int unsigned IDX_W  = $clog2(N_NEURONS);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam int unsigned SUM_W  = WIDTH + 1;

    generate
        if (N_NEURONS < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0
            || REFRAC_STEPS >= 65536) begin : g_bad_param
            $error("lif_tdm_sched: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                state;
    logic [IDX_W-1:0]      idx;
    logic [WIDTH-1:0]      mem_q   [N_NEURONS];
    logic [WIDTH-1:0]      cur_q   [N_NEURONS];
    logic [WIDTH-1:0]      beta_q;
    logic [WIDTH-1:0]      thresh_q;
    logic [N_NEURONS-1:0]  spike_acc;

    logic [WIDTH-1:0]      mem_cur;
    logic [WIDTH-1:0]      cur_eff;
    logic [PROD_W-1:0]     prod;
    logic [WIDTH-1:0]      dec;
    logic [SUM_W-1:0]      sum_w;
    logic [WIDTH-1:0]      sum_sat;
    logic                  spike;
    logic [WIDTH-1:0]      mem_next;
    logic [N_NEURONS-1:0]  spike_nxt;
    logic                  last;

`ifdef LIF_REFRAC_EN
    localparam int unsigned RC_W = $clog2(REFRAC_STEPS + 1);
    logic [RC_W-1:0]       rc_q [N_NEURONS];
    logic                  refrac_act;
`endif

    // Shared LIF update for the neuron currently addressed by idx
    always_comb begin
        mem_cur  = mem_q[idx];
        cur_eff  = cur_q[idx];
`ifdef LIF_REFRAC_EN
        refrac_act = (rc_q[idx] != '0);
        if (refrac_act) cur_eff = '0;
`endif
        prod     = PROD_W'(mem_cur) * PROD_W'(beta_q);
        dec      = WIDTH'(prod >> WIDTH);
        sum_w    = SUM_W'(dec) + SUM_W'(cur_eff);
        sum_sat  = sum_w[WIDTH] ? '1 : sum_w[WIDTH-1:0];
        spike    = (sum_sat >= thresh_q);
`ifdef LIF_REFRAC_EN
        if (refrac_act) spike = 1'b0;
`endif
        mem_next = spike ? (sum_sat - thresh_q) : sum_sat;
        spike_nxt      = spike_acc;
        spike_nxt[idx] = spike;
        last     = (idx == IDX_W'(N_NEURONS - 1));
    end

    // Sweep FSM and membrane register file
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            beta_q      <= '0;
            thresh_q    <= '0;
            done_o      <= 1'b0;
            spike_vec_o <= '0;
            spike_acc   <= '0;
            for (int k = 0; k < int'(N_NEURONS); k++) begin
                mem_q[k] <= '0;
                cur_q[k] <= '0;
`ifdef LIF_REFRAC_EN
                rc_q[k]  <= '0;
`endif
            end
        end else begin
            done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (step_i) begin
                        for (int k = 0; k < int'(N_NEURONS); k++) begin
                            cur_q[k] <= cur_i[k*WIDTH +: WIDTH];
                        end
                        beta_q    <= beta_i;
                        thresh_q  <= thresh_i;
                        idx       <= '0;
                        spike_acc <= '0;
                        state     <= SWEEP;
                    end
                end
                SWEEP: begin
                    mem_q[idx] <= mem_next;
                    spike_acc  <= spike_nxt;
`ifdef LIF_REFRAC_EN
                    if (spike)           rc_q[idx] <= RC_W'(REFRAC_STEPS);
                    else if (refrac_act) rc_q[idx] <= rc_q[idx] - RC_W'(1);
`endif
                    idx <= idx + IDX_W'(1);
                    if (last) begin
                        state       <= DONE;
                        done_o      <= 1'b1;
                        spike_vec_o <= spike_nxt;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy_o   = (state != IDLE);
    assign rd_mem_o = mem_q[rd_sel_i];

    // Spike event FIFO; a full FIFO still accepts a push on an edge that also pops
    logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] fifo_cnt;
    logic             push;
    logic             pop;
    logic             full;
    logic             push_ok;
    logic             drop;

    always_comb begin
        push    = (state == SWEEP) && spike;
        pop     = ev_valid_o && ev_ready_i;
        full    = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        push_ok = push && (!full || pop);
        drop    = push && full && !pop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int k = 0; k < int'(FIFO_DEPTH); k++) begin
                fifo_mem[k] <= '0;
            end
        end else begin
            if (push_ok) begin
                fifo_mem[wr_ptr] <= idx;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            fifo_cnt <= fifo_cnt + CNT_W'(push_ok) - CNT_W'(pop);
        end
    end

    assign ev_valid_o = (fifo_cnt != '0);
    assign ev_id_o    = fifo_mem[rd_ptr];

    // Sticky flags; a set on the same edge as a clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_o       <= 1'b0;
            step_miss_o <= 1'b0;
        end else begin
            if (drop)             ovf_o <= 1'b1;
            else if (clr_flags_i) ovf_o <= 1'b0;
            if (step_i && state != IDLE) step_miss_o <= 1'b1;
            else if (clr_flags_i)        step_miss_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lif_tdm_sched.sv
// Directed self-checking bench for lif_tdm_sched (N=4, WIDTH=8, FIFO_DEPTH=4).
module tb_lif_tdm_sched;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           step_i = 1'b0;
    logic [N*W-1:0] cur_i = '0;
    logic [W-1:0]   beta_i = '0;
    logic [W-1:0]   thresh_i = '0;
    logic           clr_flags_i = 1'b0;
    logic [1:0]     rd_sel_i = '0;
    logic [W-1:0]   rd_mem_o;
    logic           busy_o;
    logic           done_o;
    logic [N-1:0]   spike_vec_o;
    logic           ev_valid_o;
    logic [1:0]     ev_id_o;
    logic           ev_ready_i = 1'b0;
    logic           ovf_o;
    logic           step_miss_o;

    int total = 0;
    int bad   = 0;

    lif_tdm_sched #(.N_NEURONS(N), .WIDTH(W), .FIFO_DEPTH(4), .REFRAC_STEPS(2)) dut (
        .clk(clk), .rst_n(rst_n), .step_i(step_i), .cur_i(cur_i), .beta_i(beta_i),
        .thresh_i(thresh_i), .clr_flags_i(clr_flags_i), .rd_sel_i(rd_sel_i),
        .rd_mem_o(rd_mem_o), .busy_o(busy_o), .done_o(done_o), .spike_vec_o(spike_vec_o),
        .ev_valid_o(ev_valid_o), .ev_id_o(ev_id_o), .ev_ready_i(ev_ready_i),
        .ovf_o(ovf_o), .step_miss_o(step_miss_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0; step_i = 1'b0; clr_flags_i = 1'b0; ev_ready_i = 1'b0;
        #3;
        rst_n = 1'b1;
        tick();
    endtask

    function automatic logic [N*W-1:0] pack(input logic [W-1:0] c0, c1, c2, c3);
        return {c3, c2, c1, c0};
    endfunction

    task automatic read_mem(input int k, output logic [W-1:0] v);
        rd_sel_i = 2'(k);
        #1;
        v = rd_mem_o;
    endtask

    task automatic start_step(input logic [N*W-1:0] cur, input logic [W-1:0] b, input logic [W-1:0] th);
        cur_i = cur; beta_i = b; thresh_i = th; step_i = 1'b1;
        tick();
        step_i = 1'b0;
    endtask

    task automatic finish_sweep;
        repeat (N + 1) tick();
    endtask

    task automatic test_reset;
        logic [W-1:0] v;
        rst_n = 1'b0;
        #2;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done: got %b expected 0", done_o); end
        total++; if (ev_valid_o !== 1'b0) begin bad++; $display("FAIL reset_ev_valid: got %b expected 0", ev_valid_o); end
        total++; if ({ovf_o, step_miss_o, spike_vec_o} !== 6'b0) begin bad++; $display("FAIL reset_flags_vec: got %b expected 0", {ovf_o, step_miss_o, spike_vec_o}); end
        rst_n = 1'b1;
        tick();
        start_step(pack(8'd200, 8'd0, 8'd0, 8'd0), 8'hFF, 8'd100);
        tick();
        read_mem(0, v);
        total++; if (v !== 8'd100) begin bad++; $display("FAIL pre_reset_mem0: got %0d expected 100", v); end
        total++; if (ev_valid_o !== 1'b1) begin bad++; $display("FAIL pre_reset_ev_valid: got %b expected 1", ev_valid_o); end
        tick();
        #1 rst_n = 1'b0;
        #1;
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL async_reset_busy: got %b expected 0", busy_o); end
        total++; if (ev_valid_o !== 1'b0) begin bad++; $display("FAIL async_reset_ev_valid: got %b expected 0", ev_valid_o); end
        total++; if (rd_mem_o !== 8'd0) begin bad++; $display("FAIL async_reset_mem0: got %0d expected 0", rd_mem_o); end
        rst_n = 1'b1;
        tick();
        for (int k = 0; k < N; k++) begin
            read_mem(k, v);
            total++; if (v !== 8'd0) begin bad++; $display("FAIL post_reset_mem%0d: got %0d expected 0", k, v); end
        end
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
    endtask

    task automatic test_single_step;
        logic [W-1:0] v;
        do_reset();
        start_step(pack(8'd200, 8'd0, 8'd0, 8'd0), 8'hFF, 8'd100);
        for (int i = 1; i < N; i++) begin
            tick();
            total++; if (done_o !== 1'b0) begin bad++; $display("FAIL done_early_%0d: got %b expected 0", i, done_o); end
        end
        tick();
        total++; if (done_o !== 1'b1) begin bad++; $display("FAIL done_pulse: got %b expected 1", done_o); end
        total++; if (spike_vec_o !== 4'b0001) begin bad++; $display("FAIL single_spike_vec: got %b expected 0001", spike_vec_o); end
        tick();
        total++; if ({done_o, busy_o} !== 2'b00) begin bad++; $display("FAIL done_busy_after: got %b expected 00", {done_o, busy_o}); end
        read_mem(0, v);
        total++; if (v !== 8'd100) begin bad++; $display("FAIL single_mem0: got %0d expected 100", v); end
        read_mem(1, v);
        total++; if (v !== 8'd0) begin bad++; $display("FAIL single_mem1: got %0d expected 0", v); end
        total++; if ({ev_valid_o, ev_id_o} !== 3'b100) begin bad++; $display("FAIL single_event: got %b expected 100", {ev_valid_o, ev_id_o}); end
        ev_ready_i = 1'b1;
        tick();
        ev_ready_i = 1'b0;
        total++; if (ev_valid_o !== 1'b0) begin bad++; $display("FAIL single_pop: got %b expected 0", ev_valid_o); end
    endtask

    task automatic test_leak_sat;
        logic [W-1:0] v;
        logic [W-1:0] exp_mem [3];
        exp_mem[0] = 8'd40; exp_mem[1] = 8'd60; exp_mem[2] = 8'd70;
        do_reset();
        for (int s = 0; s < 3; s++) begin
            start_step(pack(8'd0, 8'd40, 8'd0, 8'd0), 8'h80, 8'hFF);
            finish_sweep();
            read_mem(1, v);
            total++; if (v !== exp_mem[s]) begin bad++; $display("FAIL leak_mem1_step%0d: got %0d expected %0d", s, v, exp_mem[s]); end
            total++; if (ev_valid_o !== 1'b0) begin bad++; $display("FAIL leak_no_event%0d: got %b expected 0", s, ev_valid_o); end
        end
        start_step(pack(8'd0, 8'd0, 8'd100, 8'd0), 8'hFF, 8'hFF);
        finish_sweep();
        read_mem(2, v);
        total++; if (v !== 8'd100) begin bad++; $display("FAIL sat_setup_mem2: got %0d expected 100", v); end
        start_step(pack(8'd0, 8'd0, 8'd250, 8'd0), 8'hFF, 8'hFF);
        finish_sweep();
        read_mem(2, v);
        total++; if (v !== 8'd0) begin bad++; $display("FAIL sat_mem2: got %0d expected 0", v); end
        read_mem(1, v);
        total++; if (v !== 8'd68) begin bad++; $display("FAIL sat_mem1_decay: got %0d expected 68", v); end
        total++; if (spike_vec_o !== 4'b0100) begin bad++; $display("FAIL sat_spike_vec: got %b expected 0100", spike_vec_o); end
        total++; if ({ev_valid_o, ev_id_o} !== 3'b110) begin bad++; $display("FAIL sat_event: got %b expected 110", {ev_valid_o, ev_id_o}); end
        ev_ready_i = 1'b1;
        tick();
        ev_ready_i = 1'b0;
    endtask

    task automatic test_overflow;
        logic [W-1:0] v;
        do_reset();
        start_step(pack(8'd10, 8'd10, 8'd10, 8'd10), 8'h00, 8'h00);
        finish_sweep();
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_after_fill: got %b expected 0", ovf_o); end
        total++; if (spike_vec_o !== 4'b1111) begin bad++; $display("FAIL thresh0_spike_vec: got %b expected 1111", spike_vec_o); end
        start_step(pack(8'd10, 8'd10, 8'd10, 8'd10), 8'h00, 8'h00);
        finish_sweep();
        total++; if (ovf_o !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1", ovf_o); end
        read_mem(3, v);
        total++; if (v !== 8'd10) begin bad++; $display("FAIL thresh0_mem3: got %0d expected 10", v); end
        for (int k = 0; k < 4; k++) begin
            total++; if ({ev_valid_o, ev_id_o} !== {1'b1, 2'(k)}) begin bad++; $display("FAIL drain_%0d: got %b expected %b", k, {ev_valid_o, ev_id_o}, {1'b1, 2'(k)}); end
            ev_ready_i = 1'b1;
            tick();
            ev_ready_i = 1'b0;
        end
        total++; if ({ev_valid_o, ovf_o} !== 2'b01) begin bad++; $display("FAIL drained_ovf_held: got %b expected 01", {ev_valid_o, ovf_o}); end
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %b expected 0", ovf_o); end
    endtask

    task automatic test_full_push_pop;
        int n;
        start_step(pack(8'd10, 8'd10, 8'd10, 8'd10), 8'h00, 8'h00);
        finish_sweep();
        start_step(pack(8'd10, 8'd10, 8'd10, 8'd10), 8'h00, 8'h00);
        ev_ready_i = 1'b1;
        repeat (N) tick();
        ev_ready_i = 1'b0;
        tick();
        total++; if (ovf_o !== 1'b0) begin bad++; $display("FAIL full_push_pop_ovf: got %b expected 0", ovf_o); end
        n = 0;
        for (int k = 0; k < 4; k++) begin
            total++; if ({ev_valid_o, ev_id_o} !== {1'b1, 2'(k)}) begin bad++; $display("FAIL full_drain_%0d: got %b expected %b", k, {ev_valid_o, ev_id_o}, {1'b1, 2'(k)}); end
            ev_ready_i = 1'b1;
            tick();
            ev_ready_i = 1'b0;
            n++;
        end
        total++; if (ev_valid_o !== 1'b0) begin bad++; $display("FAIL full_drain_empty_after_%0d: got %b expected 0", n, ev_valid_o); end
    endtask

    task automatic test_busy_step;
        logic [W-1:0] v;
        do_reset();
        start_step(pack(8'd1, 8'd2, 8'd3, 8'd4), 8'h00, 8'hFF);
        cur_i = pack(8'd9, 8'd9, 8'd9, 8'd9);
        step_i = 1'b1;
        clr_flags_i = 1'b1;
        tick();
        step_i = 1'b0;
        clr_flags_i = 1'b0;
        total++; if (step_miss_o !== 1'b1) begin bad++; $display("FAIL step_miss_set_wins: got %b expected 1", step_miss_o); end
        repeat (N) tick();
        total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL busy_step_idle: got %b expected 0", busy_o); end
        for (int k = 0; k < N; k++) begin
            read_mem(k, v);
            total++; if (v !== 8'(k + 1)) begin bad++; $display("FAIL busy_mem%0d: got %0d expected %0d", k, v, k + 1); end
        end
        clr_flags_i = 1'b1;
        tick();
        clr_flags_i = 1'b0;
        total++; if (step_miss_o !== 1'b0) begin bad++; $display("FAIL step_miss_clear: got %b expected 0", step_miss_o); end
        start_step(pack(8'd5, 8'd6, 8'd7, 8'd8), 8'h00, 8'hFF);
        total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL next_step_busy: got %b expected 1", busy_o); end
        finish_sweep();
        read_mem(3, v);
        total++; if (v !== 8'd8) begin bad++; $display("FAIL next_step_mem3: got %0d expected 8", v); end
        total++; if (step_miss_o !== 1'b0) begin bad++; $display("FAIL next_step_no_miss: got %b expected 0", step_miss_o); end
    endtask

`ifdef LIF_REFRAC_EN
    task automatic test_refrac;
        logic [W-1:0] v;
        logic [W-1:0] exp_mem [4];
        logic         exp_spk [4];
        exp_mem[0] = 8'd100; exp_mem[1] = 8'd99; exp_mem[2] = 8'd98; exp_mem[3] = 8'd155;
        exp_spk[0] = 1'b1;   exp_spk[1] = 1'b0;  exp_spk[2] = 1'b0;  exp_spk[3] = 1'b1;
        do_reset();
        for (int s = 0; s < 4; s++) begin
            start_step(pack(8'd200, 8'd0, 8'd0, 8'd0), 8'hFF, 8'd100);
            finish_sweep();
            read_mem(0, v);
            total++; if (v !== exp_mem[s]) begin bad++; $display("FAIL refrac_mem_step%0d: got %0d expected %0d", s, v, exp_mem[s]); end
            total++; if (spike_vec_o[0] !== exp_spk[s]) begin bad++; $display("FAIL refrac_spike_step%0d: got %b expected %b", s, spike_vec_o[0], exp_spk[s]); end
            total++; if (ev_valid_o !== exp_spk[s]) begin bad++; $display("FAIL refrac_event_step%0d: got %b expected %b", s, ev_valid_o, exp_spk[s]); end
            if (ev_valid_o) begin
                ev_ready_i = 1'b1;
                tick();
                ev_ready_i = 1'b0;
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_step();
        test_leak_sat();
        test_overflow();
        test_full_push_pop();
        test_busy_step();
`ifdef LIF_REFRAC_EN
        test_refrac();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
